// File: rtl/save_bank.sv
// rtl/save_bank.sv - save register with DEPTH-entry circular history and recall by age
module save_bank #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             okSAVE,
  input  logic [WIDTH-1:0] num,
  input  logic             okLOAD,
  input  logic [AW-1:0]    load_idx,
  output logic [WIDTH-1:0] q,
  output logic             recall_valid,
  output logic             load_err,
  output logic             save_err,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic          ALLOW_OVERWRITE = (OVERWRITE != 0);
  localparam logic [AW:0]   COUNT_MAX       = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic             recall_valid_q, recall_valid_d;
  logic             load_err_q, load_err_d;
  logic             save_err_q, save_err_d;
  logic             mem_we;
  logic [AW-1:0]    rd_addr;

  // Age 0 is the slot just behind the write pointer.
  assign rd_addr = wptr_q - AW'(1) - load_idx;
  assign full    = (count_q == COUNT_MAX);
  assign empty   = (count_q == '0);

  always_comb begin
    q_d            = q_q;
    wptr_d         = wptr_q;
    count_d        = count_q;
    recall_valid_d = 1'b0;
    load_err_d     = 1'b0;
    save_err_d     = 1'b0;
    mem_we         = 1'b0;
    if (clear) begin
      q_d     = '0;
      wptr_d  = '0;
      count_d = '0;
    end else if (okSAVE) begin
      if (full && !ALLOW_OVERWRITE) begin
        save_err_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        wptr_d = wptr_q + AW'(1);
        q_d    = num;
        if (!full) begin
          count_d = count_q + (AW+1)'(1);
        end
      end
    end else if (okLOAD) begin
      if ({1'b0, load_idx} < count_q) begin
        q_d            = mem_q[rd_addr];
        recall_valid_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q            <= '0;
      wptr_q         <= '0;
      count_q        <= '0;
      recall_valid_q <= 1'b0;
      load_err_q     <= 1'b0;
      save_err_q     <= 1'b0;
    end else begin
      q_q            <= q_d;
      wptr_q         <= wptr_d;
      count_q        <= count_d;
      recall_valid_q <= recall_valid_d;
      load_err_q     <= load_err_d;
      save_err_q     <= save_err_d;
    end
  end

  // History contents are only meaningful below count, so they need no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= num;
    end
  end

  assign q            = q_q;
  assign count        = count_q;
  assign recall_valid = recall_valid_q;
  assign load_err     = load_err_q;
  assign save_err     = save_err_q;

endmodule

// File: tb/tb_save_bank.sv
// tb/tb_save_bank.sv - bench for save_bank, one overwriting and one rejecting instance
module tb_save_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, okSAVE, okLOAD;
  logic [7:0] num;
  logic [1:0] load_idx;

  logic [7:0] q0, q1;
  logic       rv0, rv1, le0, le1, se0, se1, full0, full1, empty0, empty1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  save_bank #(.WIDTH(8), .DEPTH(4), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .okSAVE(okSAVE), .num(num),
    .okLOAD(okLOAD), .load_idx(load_idx), .q(q0), .recall_valid(rv0),
    .load_err(le0), .save_err(se0), .count(cnt0), .full(full0), .empty(empty0)
  );

  save_bank #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .okSAVE(okSAVE), .num(num),
    .okLOAD(okLOAD), .load_idx(load_idx), .q(q1), .recall_valid(rv1),
    .load_err(le1), .save_err(se1), .count(cnt1), .full(full1), .empty(empty1)
  );

  always #5 clk = ~clk;

  // Model: h[k][0] is the newest save, sz[k] the number of valid saves.
  logic [7:0] h  [2][4];
  int         sz [2];
  logic [7:0] mq [2];
  logic       mrv[2], mle[2], mse[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      mrv[k] = 1'b0;
      mle[k] = 1'b0;
      mse[k] = 1'b0;
      if (!rst_n || clear) begin
        sz[k] = 0;
        mq[k] = 8'h00;
      end else if (okSAVE) begin
        if (sz[k] == 4 && k == 0) begin
          mse[k] = 1'b1;
        end else begin
          for (int i = 3; i > 0; i--) h[k][i] = h[k][i-1];
          h[k][0] = num;
          if (sz[k] < 4) sz[k] = sz[k] + 1;
          mq[k] = num;
        end
      end else if (okLOAD) begin
        if (int'(load_idx) < sz[k]) begin
          mq[k]  = h[k][load_idx];
          mrv[k] = 1'b1;
        end else begin
          mle[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input int k, input logic [7:0] q, input logic [2:0] c,
                         input logic f, input logic e, input logic rv,
                         input logic le, input logic se);
    chk($sformatf("dut%0d.q", k), 32'(q), 32'(mq[k]));
    chk($sformatf("dut%0d.count", k), 32'(c), 32'(sz[k]));
    chk($sformatf("dut%0d.full", k), 32'(f), 32'(sz[k] == 4));
    chk($sformatf("dut%0d.empty", k), 32'(e), 32'(sz[k] == 0));
    chk($sformatf("dut%0d.recall_valid", k), 32'(rv), 32'(mrv[k]));
    chk($sformatf("dut%0d.load_err", k), 32'(le), 32'(mle[k]));
    chk($sformatf("dut%0d.save_err", k), 32'(se), 32'(mse[k]));
  endtask

  always @(negedge clk) begin
    chk_dut(0, q0, cnt0, full0, empty0, rv0, le0, se0);
    chk_dut(1, q1, cnt1, full1, empty1, rv1, le1, se1);
  end

  // Apply one request for one cycle; returns #1 after the sampling edge.
  task automatic cyc(input logic c, input logic s, input logic l,
                     input logic [7:0] n, input logic [1:0] idx);
    clear = c; okSAVE = s; okLOAD = l; num = n; load_idx = idx;
    @(posedge clk); #1;
    clear = 1'b0; okSAVE = 1'b0; okLOAD = 1'b0;
  endtask

  task automatic save(input logic [7:0] n);
    cyc(1'b0, 1'b1, 1'b0, n, 2'd0);
  endtask

  task automatic recall(input logic [1:0] idx);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, idx);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0; okSAVE = 1'b0; okLOAD = 1'b0;
    num = 8'h00; load_idx = 2'd0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset q", 32'(q1), 32'h0);
    chk("reset count", 32'(cnt1), 32'h0);
    chk("reset empty", 32'(empty1), 32'h1);
    chk("reset full", 32'(full1), 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("idle q", 32'(q0), 32'h0);
      chk("idle empty", 32'(empty0), 32'h1);
    end

    recall(2'd0);
    chk("empty recall load_err", 32'(le1), 32'h1);

    save(8'h11); save(8'h22); save(8'h33);
    chk("fill q", 32'(q1), 32'h33);
    chk("fill count", 32'(cnt1), 32'd3);
    recall(2'd2);
    chk("recall idx2 q", 32'(q1), 32'h11);
    chk("recall idx2 valid", 32'(rv1), 32'h1);
    idle();
    chk("recall pulse drops", 32'(rv1), 32'h0);
    recall(2'd3);
    chk("recall idx3 load_err", 32'(le1), 32'h1);
    chk("recall idx3 q held", 32'(q1), 32'h11);

    cyc(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    for (int i = 1; i <= 6; i++) save(8'(i));
    chk("wrap count", 32'(cnt1), 32'd4);
    chk("wrap full", 32'(full1), 32'h1);
    chk("no-overwrite q", 32'(q0), 32'h04);
    for (int i = 0; i < 4; i++) begin
      recall(2'(i));
      chk($sformatf("wrap recall %0d", i), 32'(q1), 32'(6 - i));
    end

    cyc(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    for (int i = 0; i < 4; i++) save(8'hA0 + 8'(i));
    save(8'hFF);
    chk("reject save_err", 32'(se0), 32'h1);
    chk("reject q", 32'(q0), 32'hA3);
    chk("reject count", 32'(cnt0), 32'd4);
    chk("overwrite q", 32'(q1), 32'hFF);
    recall(2'd0);
    chk("reject recall 0", 32'(q0), 32'hA3);
    recall(2'd3);
    chk("reject recall 3", 32'(q0), 32'hA0);

    cyc(1'b0, 1'b1, 1'b1, 8'h5A, 2'd1);
    chk("save+load q", 32'(q1), 32'h5A);
    chk("save+load no valid", 32'(rv1), 32'h0);
    chk("save+load no err", 32'(le1), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 8'h66, 2'd0);
    chk("clear+save q", 32'(q1), 32'h0);
    chk("clear+save count", 32'(cnt1), 32'd0);

    save(8'h77);
    recall(2'd0);
    chk("save then recall", 32'(q1), 32'h77);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 8'h99, 2'd0);
    chk("held clear count", 32'(cnt0), 32'd0);
    chk("held clear empty", 32'(empty0), 32'h1);
    recall(2'd0);
    chk("recall after clear", 32'(le0), 32'h1);

    save(8'h12); save(8'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("midstream reset q", 32'(q1), 32'h0);
    chk("midstream reset count", 32'(cnt1), 32'd0);
    chk("midstream reset empty", 32'(empty1), 32'h1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    recall(2'd0);
    chk("recall after reset", 32'(le1), 32'h1);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
